// File: rtl/fb_pkg.sv
// Framebuffer geometry, VGA timing constants and shared types for the scanout arbiter.
// Purely declarative; no latency and no backpressure of its own.
package fb_pkg;

    localparam int FB_W       = 320;
    localparam int FB_H       = 240;
    localparam int PAGE_WORDS = FB_W * FB_H;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } pixel_t;

    typedef logic [17:0] fb_addr_t;

    typedef enum logic {
        IDLE,
        PENDING
    } flip_state_t;

    typedef struct packed {
        logic        active;
        logic [9:0]  line;
        logic [8:0]  column;
        logic [16:0] rel_addr;
    } scan_slot_t;

    function automatic fb_addr_t page_base(input logic sel);
        return sel ? fb_addr_t'(PAGE_WORDS) : '0;
    endfunction

endpackage

// File: rtl/fb_scan_arbiter_if.sv
// Writer, page-flip and RAM signals of the framebuffer arbiter; slave is the arbiter side.
// wr_req/swap_req are held until wr_gnt/swap_ack; the RAM has one cycle read latency.
interface fb_scan_arbiter_if;
    import fb_pkg::*;

    logic        wr_req;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_gnt;
    logic        wr_err;

    logic        swap_req;
    logic        swap_ack;

    fb_addr_t    ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, swap_req, ram_rdata,
        output wr_gnt, wr_err, swap_ack, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data, swap_req, ram_rdata,
        input  wr_gnt, wr_err, swap_ack, ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/fb_scan_addr.sv
// Combinational hc/vc -> scan read slot (line, column, page-relative word address).
// Zero latency; never stalls -- the slot is a pure function of the beam position.
module fb_scan_addr
    import fb_pkg::*;
(
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    output scan_slot_t  slot
);

    logic [9:0] hc_p2;
    logic [7:0] row;
    logic       targeted;

    always_comb begin
        slot     = '0;
        targeted = 1'b0;
        hc_p2    = hc + 10'd2;

        // Fetch one fb column ahead on even hc; hc 798 prefetches column 0 of the next line.
        if (!hc[0] && (hc <= 10'(H_ACTIVE - 4))) begin
            targeted    = 1'b1;
            slot.line   = vc;
            slot.column = hc_p2[9:1];
        end else if (hc == 10'(H_TOTAL - 2)) begin
            targeted    = 1'b1;
            slot.line   = (vc == 10'(V_TOTAL - 1)) ? 10'd0 : vc + 10'd1;
            slot.column = 9'd0;
        end

        slot.active = targeted && (slot.line < 10'(V_ACTIVE));

        // Each fb row covers two screen lines; row*320 = (row<<8) + (row<<6).
        row           = slot.line[8:1];
        slot.rel_addr = ({9'd0, row} << 8) + ({9'd0, row} << 6) + {8'd0, slot.column};
    end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Single-port framebuffer arbiter: scanout reads on even hc, writer gets all other cycles, vblank page flip.
// Pixel colour lags its RAM address by 2 cycles; the writer stalls (wr_gnt low) only during read slots.
module fb_scan_arbiter
    import fb_pkg::*;
(
    input  logic              vgaclk,
    input  logic              rst,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    output logic [2:0]        pix_red,
    output logic [2:0]        pix_green,
    output logic [1:0]        pix_blue,
    output logic              front_sel,
    fb_scan_arbiter_if.slave  bus
);

    scan_slot_t  slot;
    pixel_t      pix_q;
    logic        rd_pending;
    logic        wr_in_range;
    logic        flip;
    flip_state_t state_q;
    flip_state_t state_d;

    fb_scan_addr u_scan_addr (
        .hc   (hc),
        .vc   (vc),
        .slot (slot)
    );

    assign wr_in_range = (bus.wr_addr < 17'(PAGE_WORDS));

    // Addressing uses the pre-edge front_sel, so a write granted on the flip edge lands in the old back page.
    always_comb begin
        bus.ram_addr  = page_base(front_sel) + fb_addr_t'(slot.rel_addr);
        bus.ram_we    = 1'b0;
        bus.ram_wdata = bus.wr_data;
        bus.wr_gnt    = 1'b0;
        bus.wr_err    = 1'b0;

        if (!slot.active && bus.wr_req) begin
            bus.wr_gnt = 1'b1;
            if (wr_in_range) begin
                bus.ram_we   = 1'b1;
                bus.ram_addr = page_base(~front_sel) + fb_addr_t'(bus.wr_addr);
            end else begin
                bus.wr_err = 1'b1;
            end
        end

        if (rst) begin
            bus.wr_gnt = 1'b0;
            bus.wr_err = 1'b0;
            bus.ram_we = 1'b0;
        end
    end

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            rd_pending <= 1'b0;
            pix_q      <= '0;
        end else begin
            rd_pending <= slot.active;
            if (rd_pending) begin
                pix_q <= pixel_t'(bus.ram_rdata);
            end
        end
    end

    assign pix_red   = pix_q.r;
    assign pix_green = pix_q.g;
    assign pix_blue  = pix_q.b;

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            front_sel    <= 1'b0;
            bus.swap_ack <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus.swap_ack <= flip;
            if (flip) begin
                front_sel <= ~front_sel;
            end
        end
    end

    // A request still high during the ack cycle is the tail of the one just served.
    always_comb begin
        state_d = state_q;
        flip    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.swap_req && !bus.swap_ack) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if ((hc == 10'd0) && (vc == 10'(V_ACTIVE))) begin
                    flip    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench for fb_scan_arbiter: beam position driven directly, RAM model returns column index.
module tb_fb_scan_arbiter;
    import fb_pkg::*;

    logic       vgaclk = 1'b0;
    logic       rst;
    logic [9:0] hc;
    logic [9:0] vc;
    logic [2:0] pix_red;
    logic [2:0] pix_green;
    logic [1:0] pix_blue;
    logic       front_sel;

    int vectors = 0;
    int errors  = 0;

    fb_scan_arbiter_if bus ();

    fb_scan_arbiter dut (
        .vgaclk    (vgaclk),
        .rst       (rst),
        .hc        (hc),
        .vc        (vc),
        .pix_red   (pix_red),
        .pix_green (pix_green),
        .pix_blue  (pix_blue),
        .front_sel (front_sel),
        .bus       (bus)
    );

    always #5 vgaclk = ~vgaclk;

    // Synchronous RAM model: data word = column of the addressed pixel.
    always @(posedge vgaclk) bus.ram_rdata <= 8'(bus.ram_addr % 18'd320);

    task automatic step(input int h, input int v);
        @(posedge vgaclk);
        #1;
        hc = 10'(h);
        vc = 10'(v);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr_req = 1'b1;
        bus.wr_addr = 17'd5;
        hc = 10'd1;
        vc = 10'd0;
        #2;
        vectors++; if (bus.wr_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", bus.wr_gnt); end
        vectors++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.ram_we); end
        vectors++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.wr_err); end
        vectors++; if ({pix_red, pix_green, pix_blue} !== 8'd0) begin errors++; $display("FAIL reset_pix: got %h want 00", {pix_red, pix_green, pix_blue}); end
        vectors++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front: got %b want 0", front_sel); end
        vectors++; if (bus.swap_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.swap_ack); end
        @(posedge vgaclk);
        #1;
        rst = 1'b0;
        bus.wr_req = 1'b0;
    endtask

    task automatic test_address_map();
        step(0, 3);
        vectors++; if (bus.ram_addr !== 18'd321) begin errors++; $display("FAIL addr_hc0: got %0d want 321", bus.ram_addr); end
        vectors++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL addr_we: got %b want 0", bus.ram_we); end
        step(636, 3);
        vectors++; if (bus.ram_addr !== 18'd639) begin errors++; $display("FAIL addr_hc636: got %0d want 639", bus.ram_addr); end
        step(798, 2);
        vectors++; if (bus.ram_addr !== 18'd320) begin errors++; $display("FAIL addr_wrap: got %0d want 320", bus.ram_addr); end
        step(798, 524);
        vectors++; if (bus.ram_addr !== 18'd0) begin errors++; $display("FAIL addr_frame_wrap: got %0d want 0", bus.ram_addr); end
    endtask

    task automatic test_pixel_align();
        for (int h = 0; h < 12; h++) begin
            step(h, 3);
            if (h == 9) begin
                vectors++; if ({pix_red, pix_green, pix_blue} !== 8'd4) begin errors++; $display("FAIL pix_hc9: got %0d want 4", {pix_red, pix_green, pix_blue}); end
            end
            if (h == 10 || h == 11) begin
                vectors++; if ({pix_red, pix_green, pix_blue} !== 8'd5) begin errors++; $display("FAIL pix_hc%0d: got %0d want 5", h, {pix_red, pix_green, pix_blue}); end
            end
        end
    endtask

    task automatic test_write_arb();
        bus.wr_req = 1'b1;
        bus.wr_addr = 17'd100;
        bus.wr_data = 8'hA5;
        step(4, 0);
        vectors++; if (bus.wr_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt_hc4: got %b want 0", bus.wr_gnt); end
        vectors++; if (bus.ram_addr !== 18'd3) begin errors++; $display("FAIL wr_rd_addr_hc4: got %0d want 3", bus.ram_addr); end
        step(5, 0);
        vectors++; if (bus.wr_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt_hc5: got %b want 1", bus.wr_gnt); end
        vectors++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL wr_we_hc5: got %b want 1", bus.ram_we); end
        vectors++; if (bus.ram_addr !== 18'd76900) begin errors++; $display("FAIL wr_addr_hc5: got %0d want 76900", bus.ram_addr); end
        vectors++; if (bus.ram_wdata !== 8'hA5) begin errors++; $display("FAIL wr_data_hc5: got %h want a5", bus.ram_wdata); end
        vectors++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_hc5: got %b want 0", bus.wr_err); end
        bus.wr_req = 1'b0;
    endtask

    task automatic test_blanking();
        int missed = 0;
        bus.wr_req = 1'b1;
        bus.wr_addr = 17'd200;
        for (int h = 640; h < 798; h++) begin
            step(h, 0);
            vectors++; if (bus.wr_gnt !== 1'b1) begin errors++; missed++; if (missed < 4) $display("FAIL blank_gnt hc=%0d: got %b want 1", h, bus.wr_gnt); end
        end
        step(798, 524);
        vectors++; if (bus.wr_gnt !== 1'b0) begin errors++; $display("FAIL blank_gnt_798_524: got %b want 0", bus.wr_gnt); end
        step(798, 479);
        vectors++; if (bus.wr_gnt !== 1'b1) begin errors++; $display("FAIL blank_gnt_798_479: got %b want 1", bus.wr_gnt); end
        bus.wr_req = 1'b0;
    endtask

    task automatic test_page_flip();
        bus.swap_req = 1'b1;
        step(0, 100);
        step(799, 479);
        vectors++; if (front_sel !== 1'b0) begin errors++; $display("FAIL flip_early: got %b want 0", front_sel); end
        bus.wr_req = 1'b1;
        bus.wr_addr = 17'd7;
        step(0, 480);
        vectors++; if (front_sel !== 1'b0) begin errors++; $display("FAIL flip_edge_front: got %b want 0", front_sel); end
        vectors++; if (bus.ram_addr !== 18'd76807) begin errors++; $display("FAIL flip_edge_wr_addr: got %0d want 76807", bus.ram_addr); end
        vectors++; if (bus.swap_ack !== 1'b0) begin errors++; $display("FAIL flip_edge_ack: got %b want 0", bus.swap_ack); end
        bus.wr_req = 1'b0;
        step(1, 480);
        vectors++; if (front_sel !== 1'b1) begin errors++; $display("FAIL flip_front: got %b want 1", front_sel); end
        vectors++; if (bus.swap_ack !== 1'b1) begin errors++; $display("FAIL flip_ack: got %b want 1", bus.swap_ack); end
        // Requester drops swap_req one cycle late, after the ack cycle's edge.
        @(posedge vgaclk);
        #1;
        bus.swap_req = 1'b0;
        hc = 10'd2;
        #1;
        vectors++; if (bus.swap_ack !== 1'b0) begin errors++; $display("FAIL flip_ack_once: got %b want 0", bus.swap_ack); end
        step(0, 480);
        step(1, 480);
        vectors++; if (front_sel !== 1'b1) begin errors++; $display("FAIL flip_no_double: got %b want 1", front_sel); end
        vectors++; if (bus.swap_ack !== 1'b0) begin errors++; $display("FAIL flip_no_double_ack: got %b want 0", bus.swap_ack); end
        step(0, 3);
        vectors++; if (bus.ram_addr !== 18'd77121) begin errors++; $display("FAIL flip_scan_base: got %0d want 77121", bus.ram_addr); end
        bus.wr_req = 1'b1;
        bus.wr_addr = 17'd100;
        bus.wr_data = 8'h3C;
        step(1, 3);
        vectors++; if (bus.ram_addr !== 18'd100) begin errors++; $display("FAIL flip_wr_base: got %0d want 100", bus.ram_addr); end
        vectors++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL flip_wr_we: got %b want 1", bus.ram_we); end
        bus.wr_req = 1'b0;
    endtask

    task automatic test_error();
        bus.wr_req = 1'b1;
        bus.wr_addr = 17'd76800;
        step(3, 3);
        vectors++; if (bus.wr_gnt !== 1'b1) begin errors++; $display("FAIL err_gnt: got %b want 1", bus.wr_gnt); end
        vectors++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL err_err: got %b want 1", bus.wr_err); end
        vectors++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL err_we: got %b want 0", bus.ram_we); end
        bus.wr_req = 1'b0;
        step(5, 3);
        vectors++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", bus.wr_err); end
    endtask

    task automatic test_reset_midline();
        step(8, 3);
        step(9, 3);
        step(10, 3);
        vectors++; if ({pix_red, pix_green, pix_blue} !== 8'd5) begin errors++; $display("FAIL rst_pre_pix: got %0d want 5", {pix_red, pix_green, pix_blue}); end
        bus.swap_req = 1'b1;
        step(11, 3);
        bus.swap_req = 1'b0;
        bus.wr_req = 1'b1;
        bus.wr_addr = 17'd9;
        #2;
        rst = 1'b1;
        #1;
        vectors++; if ({pix_red, pix_green, pix_blue} !== 8'd0) begin errors++; $display("FAIL rst_mid_pix: got %0d want 0", {pix_red, pix_green, pix_blue}); end
        vectors++; if (front_sel !== 1'b0) begin errors++; $display("FAIL rst_mid_front: got %b want 0", front_sel); end
        vectors++; if (bus.wr_gnt !== 1'b0) begin errors++; $display("FAIL rst_mid_gnt: got %b want 0", bus.wr_gnt); end
        @(posedge vgaclk);
        #1;
        rst = 1'b0;
        bus.wr_req = 1'b0;
        step(0, 480);
        step(1, 480);
        vectors++; if (front_sel !== 1'b0) begin errors++; $display("FAIL rst_lost_flip: got %b want 0", front_sel); end
        vectors++; if (bus.swap_ack !== 1'b0) begin errors++; $display("FAIL rst_lost_ack: got %b want 0", bus.swap_ack); end
        step(2, 480);
        vectors++; if (bus.swap_ack !== 1'b0) begin errors++; $display("FAIL rst_lost_ack2: got %b want 0", bus.swap_ack); end
    endtask

    initial begin
        rst = 1'b1;
        hc = 10'd0;
        vc = 10'd0;
        bus.wr_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.swap_req = 1'b0;
        test_reset();
        test_address_map();
        test_pixel_align();
        test_write_arb();
        test_blanking();
        test_page_flip();
        test_error();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
